// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU function codes, branch conditions, flag indices and FSM states
package alu_pkg;

    localparam logic [2:0] FUNC_ADD = 3'd1;
    localparam logic [2:0] FUNC_SUB = 3'd2;
    localparam logic [2:0] FUNC_AND = 3'd3;
    localparam logic [2:0] FUNC_OR  = 3'd4;
    localparam logic [2:0] FUNC_XOR = 3'd5;

    localparam logic [2:0] BR_NEVER  = 3'd0;
    localparam logic [2:0] BR_ALWAYS = 3'd1;
    localparam logic [2:0] BR_EQ     = 3'd2;
    localparam logic [2:0] BR_NE     = 3'd3;
    localparam logic [2:0] BR_LT     = 3'd4;
    localparam logic [2:0] BR_GE     = 3'd5;
    localparam logic [2:0] BR_VS     = 3'd6;
    localparam logic [2:0] BR_VC     = 3'd7;

    localparam int FLAG_Z = 0;
    localparam int FLAG_S = 1;
    localparam int FLAG_V = 2;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    function automatic logic is_arith(input logic [2:0] func);
        return (func == FUNC_ADD) || (func == FUNC_SUB);
    endfunction

    function automatic logic is_logic(input logic [2:0] func);
        return (func == FUNC_AND) || (func == FUNC_OR) || (func == FUNC_XOR);
    endfunction

endpackage

// File: rtl/alu_status_unit_if.sv
// rtl/alu_status_unit_if.sv - ALU beat input and writeback output handshake bundle
interface alu_status_unit_if #(
    parameter int DW  = 8,
    parameter int RAW = 3
);
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_result;
    logic           in_zero;
    logic           in_sign;
    logic           in_ovf;
    logic [2:0]     in_func;
    logic           in_flag_we;
    logic [RAW-1:0] in_rd;
    logic           wb_valid;
    logic           wb_ready;
    logic [DW-1:0]  wb_data;
    logic [RAW-1:0] wb_rd;

    modport master (
        output in_valid, in_result, in_zero, in_sign, in_ovf, in_func, in_flag_we, in_rd, wb_ready,
        input  in_ready, wb_valid, wb_data, wb_rd
    );

    modport slave (
        input  in_valid, in_result, in_zero, in_sign, in_ovf, in_func, in_flag_we, in_rd, wb_ready,
        output in_ready, wb_valid, wb_data, wb_rd
    );
endinterface

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational branch condition resolver over {V,S,Z}
module branch_cond_eval
    import alu_pkg::*;
(
    input  logic [2:0] i_flags,
    input  logic [2:0] i_br_cond,
    output logic       o_br_taken
);
    logic w_z;
    logic w_s;
    logic w_v;

    assign w_z = i_flags[FLAG_Z];
    assign w_s = i_flags[FLAG_S];
    assign w_v = i_flags[FLAG_V];

    always_comb begin
        o_br_taken = 1'b0;
        case (i_br_cond)
            BR_NEVER:  o_br_taken = 1'b0;
            BR_ALWAYS: o_br_taken = 1'b1;
            BR_EQ:     o_br_taken = w_z;
            BR_NE:     o_br_taken = !w_z;
            BR_LT:     o_br_taken = w_s ^ w_v;
            BR_GE:     o_br_taken = !(w_s ^ w_v);
            BR_VS:     o_br_taken = w_v;
            BR_VC:     o_br_taken = !w_v;
            default:   o_br_taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/alu_status_unit.sv
// rtl/alu_status_unit.sv - ALU result register, flags, sticky overflow, branch resolve
// Optional overflow trap FSM enabled by ALU_OVF_TRAP_EN.
module alu_status_unit
    import alu_pkg::*;
#(
    parameter int DW  = 8,
    parameter int RAW = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_status_unit_if.slave     bus,
    output logic [2:0]           flags,
    input  logic [2:0]           br_cond,
    output logic                 br_taken,
    output logic                 ovf_sticky,
    input  logic                 clr_sticky,
    output logic                 trap_req,
    input  logic                 trap_ack
);
    logic           r_wb_valid;
    logic [DW-1:0]  r_wb_data;
    logic [RAW-1:0] r_wb_rd;
    logic [2:0]     r_flags;
    logic           r_ovf_sticky;

    logic w_run;
    logic w_in_ready;
    logic w_accept;
    logic w_arith;
    logic w_flag_func;
    logic w_ovf_hit;
    logic w_wb_load;

    assign w_in_ready  = w_run && (!r_wb_valid || bus.wb_ready);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_arith     = is_arith(bus.in_func);
    assign w_flag_func = w_arith || is_logic(bus.in_func);
    assign w_ovf_hit   = w_accept && w_arith && bus.in_ovf;

`ifdef ALU_OVF_TRAP_EN
    state_t r_state;
    state_t w_state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:  if (w_ovf_hit) w_state_next = ST_TRAP;
            ST_TRAP: if (trap_ack)  w_state_next = ST_RUN;
            default: w_state_next = ST_RUN;
        endcase
    end

    assign w_run     = (r_state == ST_RUN);
    assign trap_req  = (r_state == ST_TRAP);
    // The offending overflow beat is dropped; flags and sticky still see it.
    assign w_wb_load = w_accept && !w_ovf_hit;
`else
    logic w_unused_trap_ack;

    assign w_unused_trap_ack = trap_ack;
    assign w_run             = 1'b1;
    assign trap_req          = 1'b0;
    assign w_wb_load         = w_accept;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_wb_rd    <= '0;
        end else if (w_wb_load) begin
            r_wb_valid <= 1'b1;
            r_wb_data  <= bus.in_result;
            r_wb_rd    <= bus.in_rd;
        end else if (bus.wb_ready) begin
            r_wb_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= 3'b000;
        end else if (w_accept && bus.in_flag_we && w_flag_func) begin
            r_flags[FLAG_Z] <= bus.in_zero;
            r_flags[FLAG_S] <= bus.in_sign;
            r_flags[FLAG_V] <= w_arith && bus.in_ovf;
        end
    end

    // Set has priority over clear so a same-cycle overflow is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_sticky <= 1'b0;
        end else if (w_ovf_hit) begin
            r_ovf_sticky <= 1'b1;
        end else if (clr_sticky) begin
            r_ovf_sticky <= 1'b0;
        end
    end

    branch_cond_eval u_branch_cond_eval (
        .i_flags    (r_flags),
        .i_br_cond  (br_cond),
        .o_br_taken (br_taken)
    );

    assign bus.in_ready = w_in_ready;
    assign bus.wb_valid = r_wb_valid;
    assign bus.wb_data  = r_wb_data;
    assign bus.wb_rd    = r_wb_rd;
    assign flags        = r_flags;
    assign ovf_sticky   = r_ovf_sticky;
endmodule

// File: tb/tb_alu_status_unit.sv
// tb/tb_alu_status_unit.sv - randomized bench for alu_status_unit against a queue-based model
module tb_alu_status_unit;
    logic       clk;
    logic       rst;
    logic [2:0] flags;
    logic [2:0] br_cond;
    logic       br_taken;
    logic       ovf_sticky;
    logic       clr_sticky;
    logic       trap_req;
    logic       trap_ack;

    alu_status_unit_if #(.DW(8), .RAW(3)) bus ();

    alu_status_unit #(.DW(8), .RAW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .flags      (flags),
        .br_cond    (br_cond),
        .br_taken   (br_taken),
        .ovf_sticky (ovf_sticky),
        .clr_sticky (clr_sticky),
        .trap_req   (trap_req),
        .trap_ack   (trap_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] rd;
        logic [7:0] data;
    } beat_t;

    beat_t m_q[$];
    logic  m_z, m_s, m_v, m_sticky, m_trap;
    int    n_checks;
    int    n_fails;

`ifdef ALU_OVF_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_ready(input logic wb_rdy);
        return !m_trap && (m_q.size() == 0 || wb_rdy);
    endfunction

    function automatic logic model_taken(input logic [2:0] cond);
        logic [7:0] table_v;
        table_v = {!m_v, m_v, !(m_s ^ m_v), m_s ^ m_v, !m_z, m_z, 1'b1, 1'b0};
        return table_v[cond];
    endfunction

    task automatic check_outputs();
        beat_t head;
        head = (m_q.size() != 0) ? m_q[0] : '0;
        check("in_ready",   32'(bus.in_ready),  32'(model_ready(bus.wb_ready)));
        check("wb_valid",   32'(bus.wb_valid),  32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("wb_data", 32'(bus.wb_data), 32'(head.data));
            check("wb_rd",   32'(bus.wb_rd),   32'(head.rd));
        end
        check("flags",      32'(flags),         32'({m_v, m_s, m_z}));
        check("br_taken",   32'(br_taken),      32'(model_taken(br_cond)));
        check("ovf_sticky", 32'(ovf_sticky),    32'(m_sticky));
        check("trap_req",   32'(trap_req),      32'(m_trap));
    endtask

    task automatic model_edge();
        logic acc, arith, logic_f, ovf_hit;
        if (rst) begin
            m_q.delete();
            {m_z, m_s, m_v, m_sticky, m_trap} = '0;
            return;
        end
        acc     = bus.in_valid && model_ready(bus.wb_ready);
        arith   = (bus.in_func == 3'd1) || (bus.in_func == 3'd2);
        logic_f = (bus.in_func >= 3'd3) && (bus.in_func <= 3'd5);
        ovf_hit = acc && arith && bus.in_ovf;
        if (m_q.size() != 0 && bus.wb_ready) void'(m_q.pop_front());
        if (acc && !(TRAP_EN && ovf_hit)) m_q.push_back({bus.in_rd, bus.in_result});
        if (acc && bus.in_flag_we && (arith || logic_f)) begin
            m_z = bus.in_zero;
            m_s = bus.in_sign;
            m_v = arith ? bus.in_ovf : 1'b0;
        end
        if (ovf_hit) m_sticky = 1'b1;
        else if (clr_sticky) m_sticky = 1'b0;
        if (TRAP_EN) begin
            if (m_trap && trap_ack) m_trap = 1'b0;
            else if (ovf_hit) m_trap = 1'b1;
        end
    endtask

    task automatic new_beat();
        bus.in_result  = 8'($urandom);
        bus.in_zero    = ($urandom_range(0, 3) == 0);
        bus.in_sign    = ($urandom_range(0, 1) == 0);
        bus.in_ovf     = ($urandom_range(0, 3) == 0);
        bus.in_func    = 3'($urandom_range(0, 7));
        bus.in_flag_we = ($urandom_range(0, 3) != 0);
        bus.in_rd      = 3'($urandom_range(0, 7));
    endtask

    initial begin
        logic hold;
        n_checks = 0;
        n_fails  = 0;
        hold     = 1'b0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.wb_ready = 1'b1;
        br_cond      = 3'd0;
        clr_sticky   = 1'b0;
        trap_ack     = 1'b0;
        new_beat();
        @(negedge clk);
        model_edge();
        @(negedge clk);
        model_edge();
        rst = 1'b0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (!hold) begin
                bus.in_valid = ($urandom_range(0, 2) != 0);
                new_beat();
            end
            bus.wb_ready = ($urandom_range(0, 3) != 0);
            br_cond      = 3'($urandom_range(0, 7));
            clr_sticky   = ($urandom_range(0, 7) == 0);
            trap_ack     = ($urandom_range(0, 3) == 0);
            rst          = ($urandom_range(0, 199) == 0);
            #1;
            check_outputs();
            hold = bus.in_valid && !model_ready(bus.wb_ready) && !rst;
            model_edge();
        end

        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check_outputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
